// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, word width,
// bubble word and the IF/ID bundle.
package fetch_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] BOOT     = 2'd0;
    localparam logic [1:0] RUN      = 2'd1;
    localparam logic [1:0] REDIRECT = 2'd2;

    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: squash loads a bubble, hold keeps contents.
// Reset and squash share the bubble value.
module ifid_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP = fetch_stage_pkg::NOP_WORD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_hold,
    input  logic            i_squash,
    input  logic [XLEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_pc,
    output ifid_t           o_ifid
);

    ifid_t r_ifid;

    always_ff @(posedge clk) begin
        if (reset || i_squash) begin
            r_ifid <= '{instr: NOP, pc: '0, pc_plus4: '0, valid: 1'b0};
        end else if (!i_hold) begin
            r_ifid <= '{instr: i_instr, pc: i_pc,
                        pc_plus4: i_pc + 32'd4, valid: 1'b1};
        end
    end

    assign o_ifid = r_ifid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/REDIRECT FSM, IF/ID.
// Define FETCH_PERF_CNT_EN to add fetch_count/stall_count outputs.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_WORD = fetch_stage_pkg::NOP_WORD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] ifid_instr,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pc_plus4,
    output logic            ifid_valid,
    output logic            align_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_count,
    output logic [31:0]     stall_count
`endif
);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic            r_align_err;
    ifid_t           w_ifid;

    // Unused encoding 2'd3 is treated like BOOT to recover safely.
    logic w_boot;
    logic w_branch;
    logic w_hold;
    logic w_adv;

    assign w_boot   = (r_state != RUN) && (r_state != REDIRECT);
    assign w_branch = !w_boot && branch_taken;
    assign w_hold   = !w_boot && !branch_taken && stall;
    assign w_adv    = !w_boot && !branch_taken && !stall;

    always_comb begin
        w_pc_nxt    = r_pc;
        w_state_nxt = r_state;
        unique case (1'b1)
            w_boot: begin
                w_state_nxt = RUN;
            end
            w_branch: begin
                w_pc_nxt    = {branch_target[31:2], 2'b00};
                w_state_nxt = REDIRECT;
            end
            w_hold: begin
                w_pc_nxt    = r_pc;
            end
            w_adv: begin
                w_pc_nxt    = r_pc + 32'd4;
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= RESET_PC;
            r_state     <= BOOT;
            r_align_err <= 1'b0;
        end else begin
            r_pc        <= w_pc_nxt;
            r_state     <= w_state_nxt;
            r_align_err <= w_branch && (branch_target[1:0] != 2'b00);
        end
    end

    ifid_reg #(
        .NOP      (NOP_WORD)
    ) u_ifid (
        .clk      (clk),
        .reset    (reset),
        .i_hold   (w_hold),
        .i_squash (w_boot || w_branch),
        .i_instr  (instruction),
        .i_pc     (r_pc),
        .o_ifid   (w_ifid)
    );

    assign pc            = r_pc;
    assign ifid_instr    = w_ifid.instr;
    assign ifid_pc       = w_ifid.pc;
    assign ifid_pc_plus4 = w_ifid.pc_plus4;
    assign ifid_valid    = w_ifid.valid;
    assign align_err     = r_align_err;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_adv) r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (w_hold) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign fetch_count = r_fetch_cnt;
    assign stall_count = r_stall_cnt;
`endif

endmodule
